usb_tx_sched: RTL and testbench
===============================

Name: usb_tx_sched

Overview:
- Transmit-side scheduler for the USB device core. It owns the single `encode_packet` transmit path and shares it between two kinds of requester: handshake requests from the OUT/receive path, and per-endpoint IN data streams.
- On each decoded IN token it picks the addressed endpoint and sends the matching response: DATA0/DATA1, NAK, STALL or a zero-length packet (ZLP).
- It tracks the DATA toggle of each endpoint and waits for the host ACK. It sits between `decode_packet` / endpoint logic and `encode_packet`.

Parameters:
- NUM_EP, 3: number of IN endpoints (EP0 = control, EP1..NUM_EP-1 = bulk).
- HIGH_SPEED, 1: selects the maximum packet size (1 → 512 bytes for bulk; 0 → 64 bytes).
- CTL_MAX_PKT, 64: EP0 maximum packet size.
- ACK_TIMEOUT, 128: cycles to wait for a host handshake after the last data byte.

Ports:
- clock  in  1  USB-domain clock (60 MHz).
- areset_n  in  1  asynchronous active-low reset.
- usb_reset_i  in  1  synchronous bus-reset; clears all toggles, aborts to IDLE.
- tok_start_i  in  1  address-matched token strobe.
- tok_type_i  in  2  token type: 00 OUT, 01 SOF, 10 IN, 11 SETUP.
- tok_ep_i  in  4  token endpoint number.
- hsk_recv_i  in  1  host handshake received strobe.
- hsk_type_i  in  2  handshake type: 00 ACK, 01 NYET, 10 NAK, 11 STALL.
- out_hsk_req_i  in  1  OUT path requests a handshake; held until granted.
- out_hsk_type_i  in  2  handshake type to send.
- out_hsk_gnt_o  out  1  one-cycle strobe: requested handshake has been sent.
- ep_halt_i  in  NUM_EP  endpoint is halted (respond STALL).
- ep_zlp_i  in  NUM_EP  endpoint requests a zero-length packet.
- ep_tvalid_i  in  NUM_EP  per-endpoint AXI4-stream valid.
- ep_tready_o  out  NUM_EP  per-endpoint AXI4-stream ready.
- ep_tlast_i  in  NUM_EP  per-endpoint AXI4-stream last.
- ep_tdata_i  in  8*NUM_EP  per-endpoint data; EP n occupies bits [8n+7:8n].
- ep_done_o  out  NUM_EP  one-cycle strobe: packet was ACKed.
- ep_retry_o  out  NUM_EP  one-cycle strobe: packet not ACKed; source must replay it.
- hsk_send_o  out  1  to encoder: send handshake.
- hsk_type_o  out  2  to encoder: handshake type.
- hsk_done_i  in  1  from encoder: handshake sent.
- trn_start_o  out  1  to encoder: data-packet start strobe.
- trn_type_o  out  2  to encoder: 00 DATA0, 10 DATA1.
- trn_tvalid_o  out  1  to encoder: data valid.
- trn_tready_i  in  1  from encoder: data ready.
- trn_tlast_o  out  1  to encoder: last byte.
- trn_tdata_o  out  8  to encoder: data byte.
- busy_o  out  1  state is not IDLE.

Behaviour:
- Reset values: all outputs 0; all toggles DATA0; state IDLE.
- States: IDLE, HSK, DSTART, DXFER, DWAIT.
- IDLE, OUT handshake request:
  - out_hsk_req_i takes priority over an IN token in the same cycle.
  - The IN token is then dropped; the host retries it.
  - Go to HSK with hsk_type_o = out_hsk_type_i.
- IDLE, IN token to endpoint e:
  - e ≥ NUM_EP or ep_halt_i[e] → HSK, STALL.
  - Else ep_tvalid_i[e] → DSTART.
  - Else ep_zlp_i[e] → DSTART, ZLP.
  - Else → HSK, NAK.
- IDLE, SETUP token to endpoint e < NUM_EP: toggle[e] ← DATA1. No transmit.
- IDLE, SOF or OUT token: ignored.
- HSK:
  - hsk_send_o is held high until hsk_done_i.
  - If the handshake was an OUT request, pulse out_hsk_gnt_o on the hsk_done_i cycle.
  - Then → IDLE.
- DSTART:
  - One cycle: trn_start_o = 1, trn_type_o = toggle[e]. Clear the byte counter.
  - ZLP: in the same cycle trn_tlast_o = 1 and trn_tvalid_o = 0, then → DWAIT.
  - Otherwise → DXFER.
- DXFER:
  - The selected endpoint is muxed to trn_*; ep_tready_o[e] = trn_tready_i; all other ep_tready_o are 0.
  - The counter increments on each handshake beat (tvalid & tready).
  - trn_tlast_o = ep_tlast_i[e] OR (counter == MAXPKT-1).
  - MAXPKT is CTL_MAX_PKT for EP0, else 512 or 64 per HIGH_SPEED. Counter width is 10 bits.
  - A beat carrying trn_tlast_o ends the packet → DWAIT.
  - Packet split at MAXPKT: the source sees no tlast consumed; the remainder goes out on the next IN.
- DWAIT: the timeout counter starts at 0.
  - hsk_recv_i & ACK: flip toggle[e], pulse ep_done_o[e] → IDLE.
  - Any other handshake type, or ACK_TIMEOUT reached: pulse ep_retry_o[e]; toggle unchanged → IDLE.
  - tok_start_i during DWAIT (host retry): treated as a timeout (pulse ep_retry_o[e]), then the token is processed from IDLE on the next cycle. The token must be registered for this.
- Tokens arriving in HSK, DSTART or DXFER are ignored.
- usb_reset_i in any state:
  - Next cycle: IDLE, all outputs deasserted, toggles DATA0.
  - If a packet was in flight (DSTART/DXFER/DWAIT), pulse ep_retry_o for it.
- The encoder contract is unchanged: trn_tvalid_o is never asserted outside DXFER.

Decomposition:
- Shared package `usb_defs`:
  - token, handshake and data-PID 2-bit encodings;
  - `MAXPKT_HS` (512), `MAXPKT_FS` (64);
  - scheduler state encoding.
- Sub-module `usb_ep_mux`: combinational NUM_EP→1 stream selector plus ready fan-out, indexed by a registered endpoint number.
- Toggles and state machine live in the top module.

Test Plan:
- IN EP1 with 3 bytes {A1,B2,C3} and tlast on C3 → trn_start_o with type 00; 3 beats, trn_tlast_o on C3; host ACK → ep_done_o[1] pulse. Next IN uses type 10.
- IN EP2 with nothing pending and no halt → hsk_send_o with type 10 (NAK) until hsk_done_i; no ep_tready_o.
- SETUP EP0, then IN EP0 with ep_zlp_i[0] → trn_start_o with type 10, trn_tlast_o = 1, trn_tvalid_o = 0; ACK → toggle[0] = DATA0.
- IN EP1 with a 600-byte stream, HIGH_SPEED = 1 → trn_tlast_o forced on byte 512. After ACK, the second IN sends 88 bytes with type 10.
- IN EP1, no host handshake for 128 cycles → ep_retry_o[1] pulse; toggle unchanged. Retransmit uses the same type.
- out_hsk_req_i (ACK) and IN token in the same cycle → ACK sent, out_hsk_gnt_o pulse, IN dropped. Also: usb_reset_i mid-DXFER → IDLE next cycle, ep_retry_o pulse, toggles reset.

Source files
------------

// File: rtl/usb_defs.sv
// Shared encodings for the USB device transmit path: token, handshake
// and data-PID codes, packet size limits and the scheduler state set.
package usb_defs;

    localparam logic [1:0] TOK_OUT   = 2'b00;
    localparam logic [1:0] TOK_SOF   = 2'b01;
    localparam logic [1:0] TOK_IN    = 2'b10;
    localparam logic [1:0] TOK_SETUP = 2'b11;

    localparam logic [1:0] HSK_ACK   = 2'b00;
    localparam logic [1:0] HSK_NYET  = 2'b01;
    localparam logic [1:0] HSK_NAK   = 2'b10;
    localparam logic [1:0] HSK_STALL = 2'b11;

    localparam logic [1:0] PID_DATA0 = 2'b00;
    localparam logic [1:0] PID_DATA1 = 2'b10;

    localparam int MAXPKT_HS = 512;
    localparam int MAXPKT_FS = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HSK,
        S_DSTART,
        S_DXFER,
        S_DWAIT
    } state_t;

endpackage

// File: rtl/usb_ep_mux.sv
// Endpoint stream selector: routes the selected endpoint's AXI4-stream
// to the encoder and fans the encoder ready back to that endpoint only.
// Ports: sel (registered endpoint), en (transfer phase active),
// ep_* (per-endpoint stream side), tready/tvalid/tlast/tdata (encoder side).
module usb_ep_mux #(
    parameter int NUM_EP = 3,
    parameter int EPW    = 2
) (
    input  logic [EPW-1:0]      sel,
    input  logic                en,
    input  logic [NUM_EP-1:0]   ep_tvalid,
    input  logic [NUM_EP-1:0]   ep_tlast,
    input  logic [8*NUM_EP-1:0] ep_tdata,
    output logic [NUM_EP-1:0]   ep_tready,
    input  logic                tready,
    output logic                tvalid,
    output logic                tlast,
    output logic [7:0]          tdata
);

    always_comb begin
        ep_tready = '0;
        tvalid    = 1'b0;
        tlast     = 1'b0;
        tdata     = 8'h00;
        for (int i = 0; i < NUM_EP; i++) begin
            if (en && sel == EPW'(i)) begin
                ep_tready[i] = tready;
                tvalid       = ep_tvalid[i];
                tlast        = ep_tlast[i];
                tdata        = ep_tdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/usb_tx_sched.sv
// Transmit scheduler: shares the encoder between OUT-path handshakes and
// per-endpoint IN data, tracks DATA0/DATA1 toggles and waits for host ACK.
// Ports: clock/areset_n, usb_reset_i, token and host handshake inputs,
// OUT handshake request/grant, endpoint streams, encoder interface, busy_o.
module usb_tx_sched
    import usb_defs::*;
#(
    parameter int NUM_EP      = 3,
    parameter int HIGH_SPEED  = 1,
    parameter int CTL_MAX_PKT = 64,
    parameter int ACK_TIMEOUT = 128
) (
    input  logic                clock,
    input  logic                areset_n,
    input  logic                usb_reset_i,
    input  logic                tok_start_i,
    input  logic [1:0]          tok_type_i,
    input  logic [3:0]          tok_ep_i,
    input  logic                hsk_recv_i,
    input  logic [1:0]          hsk_type_i,
    input  logic                out_hsk_req_i,
    input  logic [1:0]          out_hsk_type_i,
    output logic                out_hsk_gnt_o,
    input  logic [NUM_EP-1:0]   ep_halt_i,
    input  logic [NUM_EP-1:0]   ep_zlp_i,
    input  logic [NUM_EP-1:0]   ep_tvalid_i,
    output logic [NUM_EP-1:0]   ep_tready_o,
    input  logic [NUM_EP-1:0]   ep_tlast_i,
    input  logic [8*NUM_EP-1:0] ep_tdata_i,
    output logic [NUM_EP-1:0]   ep_done_o,
    output logic [NUM_EP-1:0]   ep_retry_o,
    output logic                hsk_send_o,
    output logic [1:0]          hsk_type_o,
    input  logic                hsk_done_i,
    output logic                trn_start_o,
    output logic [1:0]          trn_type_o,
    output logic                trn_tvalid_o,
    input  logic                trn_tready_i,
    output logic                trn_tlast_o,
    output logic [7:0]          trn_tdata_o,
    output logic                busy_o
);

    localparam int EPW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
    localparam int TW  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [9:0] BULK_LAST =
        (HIGH_SPEED != 0) ? 10'(MAXPKT_HS - 1) : 10'(MAXPKT_FS - 1);
    localparam logic [9:0] CTL_LAST = 10'(CTL_MAX_PKT - 1);
    localparam logic [NUM_EP-1:0] ONE = NUM_EP'(1);

    state_t            state, state_nx;
    logic [EPW-1:0]    ep_q, ep_nx;
    logic              zlp_q, zlp_nx;
    logic [1:0]        hsk_q, hsk_nx;
    logic              hsk_out_q, hsk_out_nx;
    logic [NUM_EP-1:0] tog_q, tog_nx;
    logic [9:0]        cnt_q, cnt_nx;
    logic [TW-1:0]     tmo_q, tmo_nx;
    logic              pend_q, pend_nx;
    logic [1:0]        ptype_q, ptype_nx;
    logic [3:0]        pep_q, pep_nx;

    logic              tok_v;
    logic [1:0]        tok_t;
    logic [3:0]        tok_e;
    logic [NUM_EP-1:0] tok_oh;
    logic [NUM_EP-1:0] sel_oh;
    logic [9:0]        last_cnt;
    logic              s_tvalid;
    logic              s_tlast;
    logic [7:0]        s_tdata;

    // A token caught during DWAIT is replayed from IDLE one cycle later.
    assign tok_v    = pend_q | tok_start_i;
    assign tok_t    = pend_q ? ptype_q : tok_type_i;
    assign tok_e    = pend_q ? pep_q : tok_ep_i;
    // Zero when the token addresses a non-existent endpoint.
    assign tok_oh   = ONE << tok_e;
    assign sel_oh   = ONE << ep_q;
    assign last_cnt = (ep_q == '0) ? CTL_LAST : BULK_LAST;
    assign busy_o   = (state != S_IDLE);

    usb_ep_mux #(
        .NUM_EP (NUM_EP),
        .EPW    (EPW)
    ) u_mux (
        .sel       (ep_q),
        .en        (state == S_DXFER),
        .ep_tvalid (ep_tvalid_i),
        .ep_tlast  (ep_tlast_i),
        .ep_tdata  (ep_tdata_i),
        .ep_tready (ep_tready_o),
        .tready    (trn_tready_i),
        .tvalid    (s_tvalid),
        .tlast     (s_tlast),
        .tdata     (s_tdata)
    );

    always_comb begin
        state_nx      = state;
        ep_nx         = ep_q;
        zlp_nx        = zlp_q;
        hsk_nx        = hsk_q;
        hsk_out_nx    = hsk_out_q;
        tog_nx        = tog_q;
        cnt_nx        = cnt_q;
        tmo_nx        = '0;
        pend_nx       = pend_q;
        ptype_nx      = ptype_q;
        pep_nx        = pep_q;
        out_hsk_gnt_o = 1'b0;
        hsk_send_o    = 1'b0;
        hsk_type_o    = 2'b00;
        trn_start_o   = 1'b0;
        trn_type_o    = PID_DATA0;
        trn_tvalid_o  = 1'b0;
        trn_tlast_o   = 1'b0;
        trn_tdata_o   = 8'h00;
        ep_done_o     = '0;
        ep_retry_o    = '0;
        unique case (state)
            S_IDLE: begin
                pend_nx = 1'b0;
                if (out_hsk_req_i) begin
                    state_nx   = S_HSK;
                    hsk_nx     = out_hsk_type_i;
                    hsk_out_nx = 1'b1;
                end else if (tok_v && tok_t == TOK_IN) begin
                    hsk_out_nx = 1'b0;
                    ep_nx      = tok_e[EPW-1:0];
                    if (tok_oh == '0 || (ep_halt_i & tok_oh) != '0) begin
                        state_nx = S_HSK;
                        hsk_nx   = HSK_STALL;
                    end else if ((ep_tvalid_i & tok_oh) != '0) begin
                        state_nx = S_DSTART;
                        zlp_nx   = 1'b0;
                    end else if ((ep_zlp_i & tok_oh) != '0) begin
                        state_nx = S_DSTART;
                        zlp_nx   = 1'b1;
                    end else begin
                        state_nx = S_HSK;
                        hsk_nx   = HSK_NAK;
                    end
                end else if (tok_v && tok_t == TOK_SETUP) begin
                    tog_nx = tog_q | tok_oh;
                end
            end
            S_HSK: begin
                hsk_send_o = 1'b1;
                hsk_type_o = hsk_q;
                if (hsk_done_i) begin
                    out_hsk_gnt_o = hsk_out_q;
                    state_nx      = S_IDLE;
                end
            end
            S_DSTART: begin
                trn_start_o = 1'b1;
                trn_type_o  = ((tog_q & sel_oh) != '0) ? PID_DATA1 : PID_DATA0;
                cnt_nx      = '0;
                if (zlp_q) begin
                    trn_tlast_o = 1'b1;
                    state_nx    = S_DWAIT;
                end else begin
                    state_nx = S_DXFER;
                end
            end
            S_DXFER: begin
                trn_tvalid_o = s_tvalid;
                trn_tdata_o  = s_tdata;
                // Forced tlast splits an over-long transfer at MAXPKT.
                trn_tlast_o  = s_tlast | (cnt_q == last_cnt);
                if (s_tvalid && trn_tready_i) begin
                    cnt_nx = cnt_q + 10'd1;
                    if (trn_tlast_o) begin
                        state_nx = S_DWAIT;
                    end
                end
            end
            S_DWAIT: begin
                tmo_nx = tmo_q + TW'(1);
                if (hsk_recv_i && hsk_type_i == HSK_ACK) begin
                    ep_done_o = sel_oh;
                    tog_nx    = tog_q ^ sel_oh;
                    state_nx  = S_IDLE;
                end else if (hsk_recv_i || tok_start_i ||
                             tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                    ep_retry_o = sel_oh;
                    state_nx   = S_IDLE;
                end
                if (tok_start_i) begin
                    pend_nx  = 1'b1;
                    ptype_nx = tok_type_i;
                    pep_nx   = tok_ep_i;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        if (usb_reset_i) begin
            state_nx      = S_IDLE;
            tog_nx        = '0;
            pend_nx       = 1'b0;
            ep_done_o     = '0;
            out_hsk_gnt_o = 1'b0;
            ep_retry_o    = (state == S_DSTART || state == S_DXFER ||
                             state == S_DWAIT) ? sel_oh : '0;
        end
    end

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            state     <= S_IDLE;
            ep_q      <= '0;
            zlp_q     <= 1'b0;
            hsk_q     <= 2'b00;
            hsk_out_q <= 1'b0;
            tog_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            pend_q    <= 1'b0;
            ptype_q   <= 2'b00;
            pep_q     <= 4'h0;
        end else begin
            state     <= state_nx;
            ep_q      <= ep_nx;
            zlp_q     <= zlp_nx;
            hsk_q     <= hsk_nx;
            hsk_out_q <= hsk_out_nx;
            tog_q     <= tog_nx;
            cnt_q     <= cnt_nx;
            tmo_q     <= tmo_nx;
            pend_q    <= pend_nx;
            ptype_q   <= ptype_nx;
            pep_q     <= pep_nx;
        end
    end

endmodule

// File: tb/tb_usb_tx_sched.sv
// Self-checking bench for usb_tx_sched: byte-queue endpoint sources,
// a toggle model and directed plus randomized IN transactions.
module tb_usb_tx_sched;

    localparam int NEP = 3;
    localparam int TMO = 128;

    logic            clock = 1'b0;
    logic            areset_n;
    logic            usb_reset_i;
    logic            tok_start_i;
    logic [1:0]      tok_type_i;
    logic [3:0]      tok_ep_i;
    logic            hsk_recv_i;
    logic [1:0]      hsk_type_i;
    logic            out_hsk_req_i;
    logic [1:0]      out_hsk_type_i;
    logic            out_hsk_gnt_o;
    logic [NEP-1:0]  ep_halt_i;
    logic [NEP-1:0]  ep_zlp_i;
    logic [NEP-1:0]  ep_tvalid_i;
    logic [NEP-1:0]  ep_tready_o;
    logic [NEP-1:0]  ep_tlast_i;
    logic [8*NEP-1:0] ep_tdata_i;
    logic [NEP-1:0]  ep_done_o;
    logic [NEP-1:0]  ep_retry_o;
    logic            hsk_send_o;
    logic [1:0]      hsk_type_o;
    logic            hsk_done_i;
    logic            trn_start_o;
    logic [1:0]      trn_type_o;
    logic            trn_tvalid_o;
    logic            trn_tready_i;
    logic            trn_tlast_o;
    logic [7:0]      trn_tdata_o;
    logic            busy_o;

    always #5 clock = ~clock;

    usb_tx_sched #(
        .NUM_EP      (NEP),
        .HIGH_SPEED  (1),
        .CTL_MAX_PKT (64),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clock          (clock),
        .areset_n       (areset_n),
        .usb_reset_i    (usb_reset_i),
        .tok_start_i    (tok_start_i),
        .tok_type_i     (tok_type_i),
        .tok_ep_i       (tok_ep_i),
        .hsk_recv_i     (hsk_recv_i),
        .hsk_type_i     (hsk_type_i),
        .out_hsk_req_i  (out_hsk_req_i),
        .out_hsk_type_i (out_hsk_type_i),
        .out_hsk_gnt_o  (out_hsk_gnt_o),
        .ep_halt_i      (ep_halt_i),
        .ep_zlp_i       (ep_zlp_i),
        .ep_tvalid_i    (ep_tvalid_i),
        .ep_tready_o    (ep_tready_o),
        .ep_tlast_i     (ep_tlast_i),
        .ep_tdata_i     (ep_tdata_i),
        .ep_done_o      (ep_done_o),
        .ep_retry_o     (ep_retry_o),
        .hsk_send_o     (hsk_send_o),
        .hsk_type_o     (hsk_type_o),
        .hsk_done_i     (hsk_done_i),
        .trn_start_o    (trn_start_o),
        .trn_type_o     (trn_type_o),
        .trn_tvalid_o   (trn_tvalid_o),
        .trn_tready_i   (trn_tready_i),
        .trn_tlast_o    (trn_tlast_o),
        .trn_tdata_o    (trn_tdata_o),
        .busy_o         (busy_o)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q_data [NEP][$];
    bit         q_last [NEP][$];
    logic [8:0] sent [$];
    bit         tog [NEP];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int maxpkt(input int e);
        return (e == 0) ? 64 : 512;
    endfunction

    // Bytes the next packet should carry: up to the source's tlast, capped.
    function automatic int pkt_len(input int e);
        int n;
        n = q_data[e].size();
        for (int i = 0; i < q_last[e].size(); i++) begin
            if (q_last[e][i]) begin
                n = i + 1;
                break;
            end
        end
        return (n > maxpkt(e)) ? maxpkt(e) : n;
    endfunction

    task automatic drive_src();
        for (int i = 0; i < NEP; i++) begin
            if (q_data[i].size() != 0) begin
                ep_tvalid_i[i]       = 1'b1;
                ep_tdata_i[8*i +: 8] = q_data[i][0];
                ep_tlast_i[i]        = q_last[i][0];
            end else begin
                ep_tvalid_i[i]       = 1'b0;
                ep_tdata_i[8*i +: 8] = 8'h00;
                ep_tlast_i[i]        = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        drive_src();
    endtask

    task automatic push_pkt(input int e, input int len);
        for (int k = 0; k < len; k++) begin
            q_data[e].push_back(8'($urandom_range(0, 255)));
            q_last[e].push_back(k == len - 1);
        end
    endtask

    // Source replays the bytes of an unacknowledged packet.
    task automatic replay(input int e);
        for (int i = sent.size() - 1; i >= 0; i--) begin
            q_data[e].push_front(sent[i][7:0]);
            q_last[e].push_front(sent[i][8]);
        end
        sent.delete();
    endtask

    task automatic token(input logic [1:0] t, input int e);
        drive_src();
        tok_start_i = 1'b1;
        tok_type_i  = t;
        tok_ep_i    = 4'(e);
        tick();
        tok_start_i = 1'b0;
        if (t == 2'b11 && e < NEP) tog[e] = 1'b1;
    endtask

    task automatic hsk_phase(input logic [1:0] t, input bit is_out);
        hsk_done_i = 1'b0;
        repeat (2) begin
            @(negedge clock);
            chk("hsk_send", hsk_send_o, 1);
            chk("hsk_type", hsk_type_o, t);
            chk("hsk_noready", ep_tready_o, 0);
            chk("hsk_nostart", trn_start_o, 0);
            tick();
        end
        hsk_done_i = 1'b1;
        @(negedge clock);
        chk("hsk_gnt", out_hsk_gnt_o, is_out);
        tick();
        hsk_done_i    = 1'b0;
        out_hsk_req_i = 1'b0;
        @(negedge clock);
        chk("hsk_idle", busy_o, 0);
        chk("hsk_send_off", hsk_send_o, 0);
        tick();
    endtask

    // act: 0 ACK, 1 non-ACK handshake, 2 timeout, 3 retry token.
    task automatic data_phase(input int e, input int act);
        int  n, beats, cyc, c;
        bit  zlp, beat, got;
        zlp = (q_data[e].size() == 0);
        n   = zlp ? 0 : pkt_len(e);
        sent.delete();
        @(negedge clock);
        chk("start", trn_start_o, 1);
        chk("type", trn_type_o, {tog[e], 1'b0});
        chk("start_tvalid", trn_tvalid_o, 0);
        if (zlp) chk("zlp_last", trn_tlast_o, 1);
        tick();
        if (!zlp) begin
            beats = 0;
            cyc   = 0;
            while (beats < n && cyc < 3000) begin
                trn_tready_i = ($urandom_range(0, 3) != 0);
                @(negedge clock);
                beat = 1'b0;
                chk("tvalid", trn_tvalid_o, 1);
                chk("ep_tready", ep_tready_o,
                    trn_tready_i ? (32'd1 << e) : 32'd0);
                if (trn_tready_i) begin
                    chk("tdata", trn_tdata_o, q_data[e][0]);
                    chk("tlast", trn_tlast_o, (beats + 1 == n));
                    beat = trn_tvalid_o;
                end
                @(posedge clock);
                #1;
                if (beat) begin
                    sent.push_back({q_last[e][0], q_data[e][0]});
                    void'(q_data[e].pop_front());
                    void'(q_last[e].pop_front());
                    beats++;
                end
                drive_src();
                cyc++;
            end
            trn_tready_i = 1'b0;
            chk("beats", beats, n);
        end
        case (act)
            0: begin
                hsk_recv_i = 1'b1;
                hsk_type_i = 2'b00;
                @(negedge clock);
                chk("ack_done", ep_done_o, 32'd1 << e);
                chk("ack_noretry", ep_retry_o, 0);
                tick();
                hsk_recv_i = 1'b0;
                tog[e]     = ~tog[e];
                sent.delete();
            end
            1: begin
                hsk_recv_i = 1'b1;
                hsk_type_i = 2'($urandom_range(1, 3));
                @(negedge clock);
                chk("nak_retry", ep_retry_o, 32'd1 << e);
                chk("nak_nodone", ep_done_o, 0);
                tick();
                hsk_recv_i = 1'b0;
                replay(e);
                drive_src();
            end
            2: begin
                c   = 0;
                got = 1'b0;
                while (!got && c < 300) begin
                    @(negedge clock);
                    c++;
                    if (ep_retry_o != '0) got = 1'b1;
                    else tick();
                end
                chk("tmo_cycles", c, TMO);
                chk("tmo_retry", ep_retry_o, 32'd1 << e);
                tick();
                replay(e);
                drive_src();
            end
            default: begin
                tok_start_i = 1'b1;
                tok_type_i  = 2'b10;
                tok_ep_i    = 4'(e);
                @(negedge clock);
                chk("tok_retry", ep_retry_o, 32'd1 << e);
                tick();
                tok_start_i = 1'b0;
                replay(e);
                drive_src();
                @(negedge clock);
                chk("tok_idle", busy_o, 0);
                tick();
            end
        endcase
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, act, len;
        bit b;
        areset_n       = 1'b0;
        usb_reset_i    = 1'b0;
        tok_start_i    = 1'b0;
        tok_type_i     = 2'b00;
        tok_ep_i       = 4'h0;
        hsk_recv_i     = 1'b0;
        hsk_type_i     = 2'b00;
        out_hsk_req_i  = 1'b0;
        out_hsk_type_i = 2'b00;
        ep_halt_i      = '0;
        ep_zlp_i       = '0;
        hsk_done_i     = 1'b0;
        trn_tready_i   = 1'b0;
        for (int i = 0; i < NEP; i++) tog[i] = 1'b0;
        drive_src();
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", busy_o, 0);
        chk("rst_hsk_send", hsk_send_o, 0);
        chk("rst_hsk_type", hsk_type_o, 0);
        chk("rst_start", trn_start_o, 0);
        chk("rst_type", trn_type_o, 0);
        chk("rst_tvalid", trn_tvalid_o, 0);
        chk("rst_tlast", trn_tlast_o, 0);
        chk("rst_tdata", trn_tdata_o, 0);
        chk("rst_tready", ep_tready_o, 0);
        chk("rst_done", ep_done_o, 0);
        chk("rst_retry", ep_retry_o, 0);
        chk("rst_gnt", out_hsk_gnt_o, 0);
        areset_n = 1'b1;
        tick();

        // Three-byte packet on EP1, ACKed.
        q_data[1] = '{8'hA1, 8'hB2, 8'hC3};
        q_last[1] = '{1'b0, 1'b0, 1'b1};
        token(2'b10, 1);
        data_phase(1, 0);

        // Nothing pending on EP2: NAK.
        token(2'b10, 2);
        hsk_phase(2'b10, 1'b0);

        // SETUP forces DATA1, then a ZLP on EP0.
        token(2'b11, 0);
        ep_zlp_i[0] = 1'b1;
        token(2'b10, 0);
        data_phase(0, 0);
        token(2'b10, 0);
        data_phase(0, 0);
        ep_zlp_i[0] = 1'b0;

        // 600-byte transfer split into 512 + 88.
        push_pkt(1, 600);
        token(2'b10, 1);
        data_phase(1, 0);
        chk("split_rest", q_data[1].size(), 88);
        token(2'b10, 1);
        data_phase(1, 0);

        // No host handshake: timeout, then retransmit with same PID.
        push_pkt(1, 7);
        token(2'b10, 1);
        data_phase(1, 2);
        token(2'b10, 1);
        data_phase(1, 0);

        // OUT handshake request wins over a simultaneous IN token.
        push_pkt(1, 4);
        out_hsk_req_i  = 1'b1;
        out_hsk_type_i = 2'b00;
        token(2'b10, 1);
        hsk_phase(2'b00, 1'b1);
        chk("drop_in", q_data[1].size(), 4);

        // Halted endpoint and out-of-range endpoint both STALL.
        ep_halt_i[1] = 1'b1;
        token(2'b10, 1);
        hsk_phase(2'b11, 1'b0);
        ep_halt_i[1] = 1'b0;
        token(2'b10, 5);
        hsk_phase(2'b11, 1'b0);

        // Bus reset mid-transfer.
        token(2'b11, 1);
        push_pkt(2, 30);
        token(2'b10, 2);
        @(negedge clock);
        chk("rst_xfer_start", trn_start_o, 1);
        tick();
        trn_tready_i = 1'b1;
        sent.delete();
        repeat (5) begin
            @(negedge clock);
            b = trn_tvalid_o & trn_tready_i;
            chk("rst_xfer_data", trn_tdata_o, q_data[2][0]);
            @(posedge clock);
            #1;
            if (b) begin
                sent.push_back({q_last[2][0], q_data[2][0]});
                void'(q_data[2].pop_front());
                void'(q_last[2].pop_front());
            end
            drive_src();
        end
        trn_tready_i = 1'b0;
        usb_reset_i  = 1'b1;
        @(negedge clock);
        chk("busrst_retry", ep_retry_o, 3'b100);
        tick();
        usb_reset_i = 1'b0;
        replay(2);
        drive_src();
        for (int i = 0; i < NEP; i++) tog[i] = 1'b0;
        @(negedge clock);
        chk("busrst_idle", busy_o, 0);
        chk("busrst_tvalid", trn_tvalid_o, 0);
        chk("busrst_retry_off", ep_retry_o, 0);
        tick();
        token(2'b10, 2);
        data_phase(2, 0);
        token(2'b10, 1);
        data_phase(1, 0);

        // Randomized IN traffic with mixed host responses.
        for (int it = 0; it < 14; it++) begin
            e   = $urandom_range(0, NEP - 1);
            act = $urandom_range(0, 3);
            if (q_data[e].size() == 0 && $urandom_range(0, 4) == 0) begin
                ep_zlp_i[e] = 1'b1;
            end else if (q_data[e].size() == 0) begin
                len = (e == 0) ? $urandom_range(1, 80) : $urandom_range(1, 40);
                push_pkt(e, len);
            end
            token(2'b10, e);
            data_phase(e, act);
            if (act == 1 || act == 2) begin
                token(2'b10, e);
                data_phase(e, 0);
            end else if (act == 3) begin
                data_phase(e, 0);
            end
            ep_zlp_i[e] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
